// File: rtl/fpadd_sched.sv
// fpadd_sched: schedules add/subtract operations from two requesters onto one
// shared pipelined 64-bit FP adder with a fixed latency of LAT cycles. It
// returns each result, with its tag, through a per-requester result FIFO.
//
// Optional feature: define FPADD_SCHED_SUB_EN so that rN_op=1 negates the
// second operand (subtract). If the macro is undefined, rN_op is ignored.
//
// Handshake semantics (applies to both the rN_* and qN_* channels):
// - A transfer happens in a cycle where valid and ready are both high.
// - A requester holds valid and its payload until it sees ready.
// - rN_ready depends combinationally on rN_valid and on the credit state.
// - qN_valid does not depend on qN_ready.
// - While qN_valid is high and qN_ready is low, the qN_res/qN_tag payload is stable.
module fpadd_sched #(
    parameter int LAT    = 2,
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [63:0] r0_a,
    input  logic [63:0] r0_b,
    input  logic        r0_rnd,
    input  logic        r0_op,
    input  logic [3:0]  r0_tag,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [63:0] r1_a,
    input  logic [63:0] r1_b,
    input  logic        r1_rnd,
    input  logic        r1_op,
    input  logic [3:0]  r1_tag,
    output logic [63:0] fa_a,
    output logic [63:0] fa_b,
    output logic        fa_rnd,
    input  logic [63:0] fa_res,
    output logic        q0_valid,
    input  logic        q0_ready,
    output logic [63:0] q0_res,
    output logic [3:0]  q0_tag,
    output logic        q1_valid,
    input  logic        q1_ready,
    output logic [63:0] q1_res,
    output logic [3:0]  q1_tag
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;

    // Credit = FIFO occupancy + in-flight ops owned by the requester
    logic [CW-1:0] cred [2];
    logic [CW-1:0] cnt  [2];
    logic [AW-1:0] wp   [2];
    logic [AW-1:0] rp   [2];
    logic [63:0]   f_res [2][QDEPTH];
    logic [3:0]    f_tag [2][QDEPTH];

    // Round-robin pointer: requester that wins a tie
    logic ptr;

    logic elig0, elig1, grant, gsel;
    logic [1:0] gnt_n, push, pop;
    logic [63:0] b_eff0, b_eff1;

    // Issue tracking: one {valid, owner, tag} entry per pipeline stage
    logic [LAT:1] st_v;
    logic [LAT:1] st_own;
    logic [3:0]   st_tag [1:LAT];

`ifdef FPADD_SCHED_SUB_EN
    assign b_eff0 = r0_op ? {~r0_b[63], r0_b[62:0]} : r0_b;
    assign b_eff1 = r1_op ? {~r1_b[63], r1_b[62:0]} : r1_b;
`else
    logic unused_op;
    assign unused_op = r0_op ^ r1_op;
    assign b_eff0 = r0_b;
    assign b_eff1 = r1_b;
`endif

    // Eligibility and round-robin arbitration; no grant while in reset
    always_comb begin
        elig0 = r0_valid && (cred[0] < CW'(QDEPTH));
        elig1 = r1_valid && (cred[1] < CW'(QDEPTH));
        grant = 1'b0;
        gsel  = 1'b0;
        if (!rst) begin
            if (elig0 && elig1) begin
                grant = 1'b1;
                gsel  = ptr;
            end else if (elig0) begin
                grant = 1'b1;
                gsel  = 1'b0;
            end else if (elig1) begin
                grant = 1'b1;
                gsel  = 1'b1;
            end
        end
        r0_ready = grant && !gsel;
        r1_ready = grant && gsel;
        gnt_n    = {r1_ready, r0_ready};
    end

    // Adder operand mux: granted operands or all zeros
    always_comb begin
        fa_a   = 64'd0;
        fa_b   = 64'd0;
        fa_rnd = 1'b0;
        if (grant) begin
            fa_a   = gsel ? r1_a   : r0_a;
            fa_b   = gsel ? b_eff1 : b_eff0;
            fa_rnd = gsel ? r1_rnd : r0_rnd;
        end
    end

    // Result queue outputs, push/pop strobes (no bypass: a push shows up next cycle)
    always_comb begin
        q0_valid = !rst && (cnt[0] != '0);
        q1_valid = !rst && (cnt[1] != '0);
        q0_res   = f_res[0][rp[0]];
        q0_tag   = f_tag[0][rp[0]];
        q1_res   = f_res[1][rp[1]];
        q1_tag   = f_tag[1][rp[1]];
        pop      = {q1_valid && q1_ready, q0_valid && q0_ready};
        push[0]  = st_v[LAT] && (st_own[LAT] == 1'b0);
        push[1]  = st_v[LAT] && (st_own[LAT] == 1'b1);
    end

    // Stage valids: cleared on reset so in-flight results are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            st_v <= '0;
        end else begin
            st_v[1] <= grant;
            for (int k = 2; k <= LAT; k++) st_v[k] <= st_v[k-1];
        end
    end

    // Stage owner/tag payload follows the valid bits
    always_ff @(posedge clk) begin
        st_own[1] <= gsel;
        st_tag[1] <= gsel ? r1_tag : r0_tag;
        for (int k = 2; k <= LAT; k++) begin
            st_own[k] <= st_own[k-1];
            st_tag[k] <= st_tag[k-1];
        end
    end

    // FIFO storage writes from the last tracking stage
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                f_res[n][wp[n]] <= fa_res;
                f_tag[n][wp[n]] <= st_tag[LAT];
            end
        end
    end

    // FIFO pointers, occupancy, credits and arbitration pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                wp[n]   <= '0;
                rp[n]   <= '0;
                cnt[n]  <= '0;
                cred[n] <= '0;
            end
        end else begin
            if (grant) ptr <= ~gsel;
            for (int n = 0; n < 2; n++) begin
                if (push[n]) wp[n] <= wp[n] + AW'(1);
                if (pop[n])  rp[n] <= rp[n] + AW'(1);
                cnt[n]  <= cnt[n] + CW'(push[n]) - CW'(pop[n]);
                cred[n] <= cred[n] + CW'(gnt_n[n]) - CW'(pop[n]);
            end
        end
    end

endmodule

// File: tb/tb_fpadd_sched.sv
// tb_fpadd_sched: directed and randomized checks of fpadd_sched against a
// transaction-level model (credit = queued + in-flight results, round robin).
module tb_fpadd_sched;

    localparam int LAT    = 2;
    localparam int QDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r0_rnd, r0_op;
    logic [63:0] r0_a, r0_b;
    logic [3:0]  r0_tag;
    logic        r1_valid, r1_ready, r1_rnd, r1_op;
    logic [63:0] r1_a, r1_b;
    logic [3:0]  r1_tag;
    logic [63:0] fa_a, fa_b, fa_res;
    logic        fa_rnd;
    logic        q0_valid, q0_ready, q1_valid, q1_ready;
    logic [63:0] q0_res, q1_res;
    logic [3:0]  q0_tag, q1_tag;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int g0_cnt = 0;
    int g1_cnt = 0;

    // clock / reset block
    always #5 clk = ~clk;

    fpadd_sched #(.LAT(LAT), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_rnd(r0_rnd), .r0_op(r0_op), .r0_tag(r0_tag),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_rnd(r1_rnd), .r1_op(r1_op), .r1_tag(r1_tag),
        .fa_a(fa_a), .fa_b(fa_b), .fa_rnd(fa_rnd), .fa_res(fa_res),
        .q0_valid(q0_valid), .q0_ready(q0_ready), .q0_res(q0_res), .q0_tag(q0_tag),
        .q1_valid(q1_valid), .q1_ready(q1_ready), .q1_res(q1_res), .q1_tag(q1_tag)
    );

    // Environment: ideal FP adder with a LAT-cycle delay line
    logic [63:0] add_pipe [LAT];
    always @(posedge clk) begin
        add_pipe[0] <= $realtobits($bitstoreal(fa_a) + $bitstoreal(fa_b));
        for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign fa_res = add_pipe[LAT-1];

    // Reference model state
    typedef struct {
        int          due;
        bit          own;
        logic [63:0] res;
        logic [3:0]  tag;
    } fl_t;
    fl_t         infl[$];
    logic [67:0] exp_q0[$];
    logic [67:0] exp_q1[$];
    bit          m_ptr = 1'b0;

    function automatic logic [63:0] beff(input logic op, input logic [63:0] b);
`ifdef FPADD_SCHED_SUB_EN
        return op ? $realtobits(-$bitstoreal(b)) : b;
`else
        return b;
`endif
    endfunction

    function automatic int cred(input bit n);
        int c;
        c = (n == 1'b0) ? exp_q0.size() : exp_q1.size();
        foreach (infl[i]) if (infl[i].own == n) c++;
        return c;
    endfunction

    function automatic logic [63:0] rnd_d();
        return $realtobits((real'($urandom_range(0, 4000)) - 2000.0) / 8.0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        r0_a = rnd_d(); r0_b = rnd_d(); r0_tag = 4'($urandom_range(0, 15));
        r1_a = rnd_d(); r1_b = rnd_d(); r1_tag = 4'($urandom_range(0, 15));
        r0_op = 1'($urandom_range(0, 1)); r1_op = 1'($urandom_range(0, 1));
        r0_rnd = 1'($urandom_range(0, 1)); r1_rnd = 1'($urandom_range(0, 1));
    endtask

    // One clock cycle: check outputs at negedge, advance the model at posedge
    task automatic step();
        bit e0, e1, g, gs, v0, v1, p0, p1;
        logic [63:0] ea, eb;
        logic        er;
        @(negedge clk);
        e0 = r0_valid && (cred(1'b0) < QDEPTH);
        e1 = r1_valid && (cred(1'b1) < QDEPTH);
        g = 1'b0; gs = 1'b0;
        if (!rst) begin
            if (e0 && e1) begin g = 1'b1; gs = m_ptr; end
            else if (e0 || e1) begin g = 1'b1; gs = e1; end
        end
        ea = '0; eb = '0; er = 1'b0;
        if (g) begin
            ea = gs ? r1_a : r0_a;
            eb = gs ? beff(r1_op, r1_b) : beff(r0_op, r0_b);
            er = gs ? r1_rnd : r0_rnd;
        end
        chk("r0_ready", {63'd0, r0_ready}, {63'd0, g && !gs});
        chk("r1_ready", {63'd0, r1_ready}, {63'd0, g && gs});
        chk("fa_a", fa_a, ea);
        chk("fa_b", fa_b, eb);
        chk("fa_rnd", {63'd0, fa_rnd}, {63'd0, er});
        v0 = !rst && (exp_q0.size() > 0);
        v1 = !rst && (exp_q1.size() > 0);
        chk("q0_valid", {63'd0, q0_valid}, {63'd0, v0});
        chk("q1_valid", {63'd0, q1_valid}, {63'd0, v1});
        if (v0) begin
            chk("q0_res", q0_res, exp_q0[0][63:0]);
            chk("q0_tag", {60'd0, q0_tag}, {60'd0, exp_q0[0][67:64]});
        end
        if (v1) begin
            chk("q1_res", q1_res, exp_q1[0][63:0]);
            chk("q1_tag", {60'd0, q1_tag}, {60'd0, exp_q1[0][67:64]});
        end
        p0 = v0 && q0_ready;
        p1 = v1 && q1_ready;
        @(posedge clk);
        if (rst) begin
            infl.delete();
            exp_q0.delete();
            exp_q1.delete();
            m_ptr = 1'b0;
        end else begin
            if (p0) void'(exp_q0.pop_front());
            if (p1) void'(exp_q1.pop_front());
            while (infl.size() > 0 && infl[0].due == cyc) begin
                if (infl[0].own) exp_q1.push_back({infl[0].tag, infl[0].res});
                else             exp_q0.push_back({infl[0].tag, infl[0].res});
                void'(infl.pop_front());
            end
            if (g) begin
                infl.push_back('{cyc + LAT, gs,
                    $realtobits($bitstoreal(ea) + $bitstoreal(eb)),
                    gs ? r1_tag : r0_tag});
                m_ptr = !gs;
                if (gs) g1_cnt++; else g0_cnt++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int base0, base1;
        rst = 1'b1;
        r0_valid = 0; r1_valid = 0; q0_ready = 1; q1_ready = 1;
        r0_a = '0; r0_b = '0; r0_rnd = 0; r0_op = 0; r0_tag = '0;
        r1_a = '0; r1_b = '0; r1_rnd = 0; r1_op = 0; r1_tag = '0;
        #1;
        steps(2);

        // Single add: 1.0 + 2.0 with tag 5, result visible three cycles after issue
        rst = 1'b0;
        r0_valid = 1; r0_a = 64'h3FF0000000000000; r0_b = 64'h4000000000000000;
        r0_tag = 4'd5; r0_rnd = 1;
        step();
        r0_valid = 0;
        steps(2);
        #3;
        chk("dir_q0_valid", {63'd0, q0_valid}, 64'd1);
        chk("dir_q0_res", q0_res, 64'h4008000000000000);
        chk("dir_q0_tag", {60'd0, q0_tag}, 64'd5);
        steps(3);

        // Sign flip of b on subtract (or pass-through without the feature)
        r1_valid = 1; r1_op = 1; r1_a = 64'h3FF0000000000000; r1_b = 64'h4000000000000000;
        #3;
`ifdef FPADD_SCHED_SUB_EN
        chk("dir_fa_b_sub", fa_b, 64'hC000000000000000);
`else
        chk("dir_fa_b_nosub", fa_b, 64'h4000000000000000);
`endif
        step();
        r1_valid = 0;
        steps(5);

        // Reset, then both requesters valid continuously: alternation from r0
        rst = 1; step(); rst = 0;
        r0_valid = 1; r1_valid = 1;
        for (int i = 0; i < 20; i++) begin rand_ops(); step(); end
        r0_valid = 0; r1_valid = 0;
        steps(6);

        // Credit limit: r0 stalls after QDEPTH grants, one pop frees one slot
        base0 = g0_cnt;
        q0_ready = 0; r0_valid = 1; rand_ops();
        steps(10);
        chk("credit_stall_grants", 64'(g0_cnt - base0), 64'(QDEPTH));
        q0_ready = 1; step(); q0_ready = 0;
        steps(6);
        chk("credit_one_more", 64'(g0_cnt - base0), 64'(QDEPTH + 1));
        r0_valid = 0; q0_ready = 1;
        steps(8);

        // Reset with ops in flight: results dropped, credits back to zero
        r0_valid = 1; r1_valid = 1; rand_ops();
        steps(2);
        r0_valid = 0; r1_valid = 0;
        rst = 1; steps(2); rst = 0;
        steps(6);
        base0 = g0_cnt; base1 = g1_cnt;
        q0_ready = 0; q1_ready = 0; r0_valid = 1; r1_valid = 1;
        steps(12);
        chk("post_rst_r0_grants", 64'(g0_cnt - base0), 64'(QDEPTH));
        chk("post_rst_r1_grants", 64'(g1_cnt - base1), 64'(QDEPTH));
        r0_valid = 0; r1_valid = 0; q0_ready = 1; q1_ready = 1;
        steps(8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            r0_valid = 1'($urandom_range(0, 3) != 0);
            r1_valid = 1'($urandom_range(0, 3) != 0);
            q0_ready = 1'($urandom_range(0, 2) != 0);
            q1_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end
        r0_valid = 0; r1_valid = 0; q0_ready = 1; q1_ready = 1;
        steps(15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
